// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the waveform-dump trigger: mode encodings and trigger FSM states.
package jtframe_dump_pkg;

    localparam logic [1:0] DUMP_IMM   = 2'd0;
    localparam logic [1:0] DUMP_FRAME = 2'd1;
    localparam logic [1:0] DUMP_DL    = 2'd2;
    localparam logic [1:0] DUMP_OFF   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DONE
    } dump_state_e;

endpackage

// File: rtl/jtframe_dump_edge.sv
// Registered falling-edge detector; the history flop resets to RST_VAL so that an input
// already sitting at its idle level after reset does not produce a spurious edge.
module jtframe_dump_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic fall_o
);

    logic last_q, last_d;

    always_comb begin
        last_d = d_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= RST_VAL;
        end else begin
            last_q <= last_d;
        end
    end

    assign fall_o = last_q & ~d_i;

endmodule

// File: rtl/jtframe_dump_trig.sv
// Dump trigger generator: counts frames on vs falling edges, qualifies the end of ROM
// download after a settle period and opens/closes a one-shot dump window.
module jtframe_dump_trig
    import jtframe_dump_pkg::*;
#(
    parameter int unsigned CW      = 32,
    parameter int unsigned SETTLEW = 16,
    parameter int unsigned SETTLE  = 20000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          downloading,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] start_frame,
    input  logic [CW-1:0] stop_frame,
    output logic [CW-1:0] frame_cnt,
    output logic          dump_win,
    output logic          dump_on,
    output logic          dump_off,
    output logic          dl_done
);

    localparam logic [SETTLEW-1:0] SETTLE_VAL = SETTLEW'(SETTLE);

    logic vs_fall, dl_fall, settled;
    logic open_cond, close_cond;

    logic [CW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [SETTLEW-1:0] settle_q, settle_d;
    logic               dl_done_q, dl_done_d;
    logic               dump_win_q, dump_win_d;
    logic               dump_on_q, dump_on_d;
    logic               dump_off_q, dump_off_d;
    dump_state_e        state_q, state_d;

    jtframe_dump_edge #(
        .RST_VAL (1'b1)
    ) u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (vs),
        .fall_o (vs_fall)
    );

    jtframe_dump_edge #(
        .RST_VAL (1'b0)
    ) u_dl_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (downloading),
        .fall_o (dl_fall)
    );

    assign settled = (settle_q == SETTLE_VAL);

    // Datapath next state
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (vs_fall) begin
            frame_cnt_d = frame_cnt_q + CW'(1);
        end
        settle_d  = settled ? settle_q : settle_q + SETTLEW'(1);
        dl_done_d = dl_done_q | (dl_fall & settled);
    end

    // Mode 2 uses dl_done_d so the window opens on the same edge that registers dl_done
    always_comb begin
        case (mode)
            DUMP_IMM:   open_cond = 1'b1;
            DUMP_FRAME: open_cond = (frame_cnt_q == start_frame);
            DUMP_DL:    open_cond = dl_done_d;
            default:    open_cond = 1'b0;
        endcase
        close_cond = (stop_frame != '0) && (frame_cnt_q == stop_frame);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mode != DUMP_OFF) state_d = ARMED;
            ARMED:   if (open_cond) state_d = ACTIVE;
            ACTIVE:  if (close_cond) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dump_win_d = (state_d == ACTIVE);
        dump_on_d  = (state_q == ARMED) && (state_d == ACTIVE);
        dump_off_d = (state_q == ACTIVE) && (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            settle_q    <= '0;
            dl_done_q   <= 1'b0;
            dump_win_q  <= 1'b0;
            dump_on_q   <= 1'b0;
            dump_off_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            settle_q    <= settle_d;
            dl_done_q   <= dl_done_d;
            dump_win_q  <= dump_win_d;
            dump_on_q   <= dump_on_d;
            dump_off_q  <= dump_off_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign dump_win  = dump_win_q;
    assign dump_on   = dump_on_q;
    assign dump_off  = dump_off_q;
    assign dl_done   = dl_done_q;

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Scoreboard bench for jtframe_dump_trig: an event-level reference model predicts every
// output cycle; a negedge monitor pops and compares.
module tb_jtframe_dump_trig;

    localparam int CW     = 4;
    localparam int SETTLE = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vs;
    logic          downloading;
    logic [1:0]    mode;
    logic [CW-1:0] start_frame;
    logic [CW-1:0] stop_frame;
    logic [CW-1:0] frame_cnt;
    logic          dump_win;
    logic          dump_on;
    logic          dump_off;
    logic          dl_done;

    always #5 clk = ~clk;

    jtframe_dump_trig #(
        .CW      (CW),
        .SETTLEW (16),
        .SETTLE  (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs          (vs),
        .downloading (downloading),
        .mode        (mode),
        .start_frame (start_frame),
        .stop_frame  (stop_frame),
        .frame_cnt   (frame_cnt),
        .dump_win    (dump_win),
        .dump_on     (dump_on),
        .dump_off    (dump_off),
        .dl_done     (dl_done)
    );

    typedef struct packed {
        logic [CW-1:0] frame;
        logic          win;
        logic          on;
        logic          off;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   on_seen     = 0;
    int   off_seen    = 0;

    // Reference model: frames seen, settle time elapsed, and whether the window has
    // ever been armed/opened/closed since the last reset.
    int m_frame, m_settle;
    bit m_done, m_armed, m_opened, m_closed, m_vs_prev, m_dl_prev, m_on, m_off;

    task automatic model_edge();
        bit vfall, qual, new_done, open_now;
        if (!rst_n) begin
            m_frame = 0; m_settle = 0; m_done = 0; m_armed = 0;
            m_opened = 0; m_closed = 0; m_vs_prev = 1; m_dl_prev = 0;
            m_on = 0; m_off = 0;
            return;
        end
        vfall    = m_vs_prev && !vs;
        qual     = m_dl_prev && !downloading && (m_settle == SETTLE);
        new_done = m_done || qual;
        m_on     = 0;
        m_off    = 0;
        open_now = 0;
        if (m_armed && !m_opened) begin
            case (mode)
                2'd0:    open_now = 1;
                2'd1:    open_now = (m_frame == int'(start_frame));
                2'd2:    open_now = new_done;
                default: open_now = 0;
            endcase
            if (open_now) begin
                m_opened = 1;
                m_on     = 1;
            end
        end else if (m_opened && !m_closed && stop_frame != 0 && m_frame == int'(stop_frame)) begin
            m_closed = 1;
            m_off    = 1;
        end
        if (!m_armed && mode != 2'd3) m_armed = 1;
        if (vfall) m_frame = (m_frame + 1) % (1 << CW);
        if (m_settle < SETTLE) m_settle++;
        m_done    = new_done;
        m_vs_prev = vs;
        m_dl_prev = downloading;
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        e.frame = m_frame[CW-1:0];
        e.win   = m_opened && !m_closed;
        e.on    = m_on;
        e.off   = m_off;
        e.done  = m_done;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({frame_cnt, dump_win, dump_on, dump_off, dl_done} !== e) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL cycle_check t=%0t frame=%0d exp %0d win=%b exp %b on=%b exp %b off=%b exp %b dl_done=%b exp %b",
                             $time, frame_cnt, e.frame, dump_win, e.win, dump_on, e.on,
                             dump_off, e.off, dl_done, e.done);
            end
            if (dump_on === 1'b1) on_seen++;
            if (dump_off === 1'b1) off_seen++;
        end
    end

    task automatic mon_sync();
        @(negedge clk);
        #1;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
        mon_sync();
        on_seen  = 0;
        off_seen = 0;
    endtask

    task automatic vs_pulses(input int n);
        repeat (n) begin
            vs = 1'b0;
            idle($urandom_range(1, 3));
            vs = 1'b1;
            idle($urandom_range(2, 6));
        end
    endtask

    initial begin
        rst_n = 1'b0; vs = 1'b1; downloading = 1'b0;
        mode = 2'd0; start_frame = '0; stop_frame = '0;

        // Mode 0, close at frame 3
        mode = 2'd0; stop_frame = 4'd3;
        do_reset(3);
        vs_pulses(4);
        idle(5);
        mon_sync();
        check_count("mode0_on_pulses", on_seen, 1);
        check_count("mode0_off_pulses", off_seen, 1);

        // Mode 1, window frames 5..8
        mode = 2'd1; start_frame = 4'd5; stop_frame = 4'd8;
        do_reset(2);
        vs_pulses(10);
        idle(3);
        mon_sync();
        check_count("mode1_on_pulses", on_seen, 1);
        check_count("mode1_off_pulses", off_seen, 1);

        // Mode 2: early download end ignored, later one qualifies
        mode = 2'd2; stop_frame = '0; downloading = 1'b1;
        do_reset(3);
        idle(49);
        downloading = 1'b0;
        idle(101);
        downloading = 1'b1;
        idle(149);
        downloading = 1'b0;
        idle(5);
        vs_pulses(20);
        mon_sync();
        check_count("mode2_on_pulses", on_seen, 1);
        check_count("mode2_off_pulses", off_seen, 0);

        // Counter wraps repeatedly; DONE must hold
        mode = 2'd1; start_frame = 4'd2; stop_frame = 4'd4;
        do_reset(2);
        vs_pulses(40);
        mon_sync();
        check_count("wrap_on_pulses", on_seen, 1);
        check_count("wrap_off_pulses", off_seen, 1);

        // Mode 3: counting and download qualification only
        mode = 2'd3; downloading = 1'b1;
        do_reset(2);
        idle(150);
        downloading = 1'b0;
        vs_pulses(10);
        mon_sync();
        check_count("mode3_on_pulses", on_seen, 0);
        check_count("mode3_off_pulses", off_seen, 0);

        // Mode 0, reset while the window is open
        mode = 2'd0; stop_frame = '0;
        do_reset(2);
        vs_pulses(6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(4);
        mon_sync();
        check_count("rst_active_on_pulses", on_seen, 2);
        check_count("rst_active_off_pulses", off_seen, 0);

        // Randomised rounds, including mode/frame changes and mid-run resets
        for (int r = 0; r < 20; r++) begin
            mode        = 2'($urandom_range(0, 3));
            start_frame = CW'($urandom_range(0, 15));
            stop_frame  = CW'($urandom_range(0, 15));
            downloading = 1'($urandom);
            do_reset($urandom_range(1, 3));
            for (int c = 0; c < 300; c++) begin
                vs = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 40) == 0) downloading = ~downloading;
                if ($urandom_range(0, 60) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 60) == 0) start_frame = CW'($urandom_range(0, 15));
                if ($urandom_range(0, 80) == 0) stop_frame = CW'($urandom_range(0, 15));
                rst_n = ($urandom_range(0, 250) != 0);
                tick();
            end
            rst_n = 1'b1;
        end

        idle(2);
        mon_sync();
        check_count("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
